// File: rtl/debounce_sync.sv
// Two-flop synchroniser followed by a stability qualifier: q follows d_in only after the
// synchronised input has disagreed with q on STABLE_CYCLES consecutive clock edges.
module debounce_sync #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_QUAL   = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             differs;

    // Only the second synchroniser stage is ever looked at by the qualifier.
    assign differs = (sync2_q != level_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= d_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (differs) begin
                    state_d = ST_QUAL;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_QUAL: begin
                if (!differs) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                    level_d = ~level_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobes are computed from the same qualifying condition and registered alongside q.
    always_comb begin
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (state_q == ST_QUAL && differs && cnt_q == CNT_LAST) begin
            rise_d = ~level_q;
            fall_d = level_q;
        end
    end

    assign q    = level_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = (state_q == ST_QUAL);

endmodule
